draw_column: RTL

Renders one complete screen column of the raycast view by sequencing three `draw_vertical_line` jobs: ceiling, wall slice and floor. It sits directly upstream of `draw_vertical_line` and downstream of the raycaster, which supplies a column index, a projected wall height and colours. It converts the wall height into clamped row bounds and shades the wall colour by a distance level. It then drives the line drawer through its start/done handshake, skipping any empty segment.

---
 rtl/draw_column.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/draw_column.sv
// Sequences ceiling, wall and floor jobs for one raycast column into draw_vertical_line.
// Converts wall height into clamped, horizon-centred row bounds and shades the wall colour by distance.
module draw_column #(
  parameter int SCREEN_H = 120,
  parameter int HORIZON  = 60
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  x,
  input  logic [7:0]  wall_height,
  input  logic [17:0] wall_colour,
  input  logic [1:0]  shade,
  input  logic [17:0] ceil_colour,
  input  logic [17:0] floor_colour,
  output logic        busy,
  output logic        done,
  output logic        line_start,
  output logic [7:0]  line_x,
  output logic [6:0]  line_min_y,
  output logic [6:0]  line_max_y,
  output logic [17:0] line_colour,
  input  logic        line_done
);

  typedef enum logic [3:0] {
    IDLE, SETUP, CEIL_GO, CEIL_WAIT, WALL_GO, WALL_WAIT, FLOOR_GO, FLOOR_WAIT, FINISH
  } state_t;

  localparam logic [7:0] SCREEN_H8 = 8'(SCREEN_H);
  localparam logic [7:0] HORIZON8  = 8'(HORIZON);
  localparam logic [6:0] LAST_ROW  = 7'(SCREEN_H - 1);

  state_t      state_q, state_d;
  logic [7:0]  x_q, height_q;
  logic [17:0] wall_colour_q, ceil_colour_q, floor_colour_q;
  logic [1:0]  shade_q;
  logic [7:0]  top_q, bottom_q;
  logic [17:0] shaded_q;
  logic        wall_empty_q, floor_empty_q;

  logic [7:0]  h_c, top_c, bottom_c, ceil_max_c, floor_min_c;
  logic [17:0] shaded_c;
  logic        ceil_empty_c, wall_empty_c, floor_empty_c;

  // Bounds derive from the latched height, which is frozen for the whole column.
  always_comb begin
    h_c           = (height_q > SCREEN_H8) ? SCREEN_H8 : height_q;
    top_c         = HORIZON8 - {1'b0, h_c[7:1]};
    bottom_c      = top_c + h_c - 8'd1;
    ceil_empty_c  = (top_c == 8'd0);
    wall_empty_c  = (h_c == 8'd0);
    floor_empty_c = (bottom_c == {1'b0, LAST_ROW});
    shaded_c      = {wall_colour_q[17:12] >> shade_q,
                     wall_colour_q[11:6]  >> shade_q,
                     wall_colour_q[5:0]   >> shade_q};
    ceil_max_c    = top_q - 8'd1;
    floor_min_c   = bottom_q + 8'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      x_q            <= '0;
      height_q       <= '0;
      wall_colour_q  <= '0;
      ceil_colour_q  <= '0;
      floor_colour_q <= '0;
      shade_q        <= '0;
      top_q          <= '0;
      bottom_q       <= '0;
      shaded_q       <= '0;
      wall_empty_q   <= 1'b0;
      floor_empty_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        x_q            <= x;
        height_q       <= wall_height;
        wall_colour_q  <= wall_colour;
        ceil_colour_q  <= ceil_colour;
        floor_colour_q <= floor_colour;
        shade_q        <= shade;
      end
      if (state_q == SETUP) begin
        top_q         <= top_c;
        bottom_q      <= bottom_c;
        shaded_q      <= shaded_c;
        wall_empty_q  <= wall_empty_c;
        floor_empty_q <= floor_empty_c;
      end
    end
  end

  // A line_done coinciding with a GO pulse is dropped because GO always advances to WAIT.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       if (start) state_d = SETUP;
      SETUP: begin
        if (!ceil_empty_c)       state_d = CEIL_GO;
        else if (!wall_empty_c)  state_d = WALL_GO;
        else if (!floor_empty_c) state_d = FLOOR_GO;
        else                     state_d = FINISH;
      end
      CEIL_GO:    state_d = CEIL_WAIT;
      CEIL_WAIT: begin
        if (line_done) begin
          if (!wall_empty_q)       state_d = WALL_GO;
          else if (!floor_empty_q) state_d = FLOOR_GO;
          else                     state_d = FINISH;
        end
      end
      WALL_GO:    state_d = WALL_WAIT;
      WALL_WAIT: begin
        if (line_done) state_d = floor_empty_q ? FINISH : FLOOR_GO;
      end
      FLOOR_GO:   state_d = FLOOR_WAIT;
      FLOOR_WAIT: if (line_done) state_d = FINISH;
      FINISH:     state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != IDLE);
    done        = (state_q == FINISH);
    line_start  = (state_q == CEIL_GO) || (state_q == WALL_GO) || (state_q == FLOOR_GO);
    line_x      = x_q;
    line_min_y  = '0;
    line_max_y  = '0;
    line_colour = '0;
    unique case (state_q)
      CEIL_GO, CEIL_WAIT: begin
        line_max_y  = ceil_max_c[6:0];
        line_colour = ceil_colour_q;
      end
      WALL_GO, WALL_WAIT: begin
        line_min_y  = top_q[6:0];
        line_max_y  = bottom_q[6:0];
        line_colour = shaded_q;
      end
      FLOOR_GO, FLOOR_WAIT: begin
        line_min_y  = floor_min_c[6:0];
        line_max_y  = LAST_ROW;
        line_colour = floor_colour_q;
      end
      default: ;
    endcase
  end

endmodule
